uart_echo_buf: RTL and testbench

Parametrised successor to the team's single-byte UART loopback glue. It sits between the existing uart_rx and uart_tx instances and buffers received words in a FIFO, so back-to-back characters are no longer lost while the transmitter is busy. It adds an echo enable, optional CR->CRLF expansion, an LED latch, and a sticky overrun flag.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync_fifo.sv | 63 ++++++
 rtl/uart_echo_buf.sv | 136 +++++++++++++
 tb/tb_uart_echo_buf.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART glue blocks.
// Holds the echo FSM state type, ASCII codes and a log2 helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_SEND_LF
    } uart_echo_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned log2c(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous word FIFO with occupancy count and head-of-queue read data.
// A push at full is accepted only when a pop frees a slot in the same cycle.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_echo_buf.sv
// Buffered UART echo between uart_rx and uart_tx with optional CR->CRLF,
// LED latch of the last received word and a sticky overrun flag.
module uart_echo_buf
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ACK_TO = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              echo_en,
    input  logic              crlf_en,
    input  logic              clr_overrun,
    output logic [DATA_W-1:0] led_output,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overrun
);

    localparam int TO_W = log2c(ACK_TO + 1);
    localparam bit CRLF_OK = (DATA_W >= 8);
    localparam logic [DATA_W-1:0] CR_W = DATA_W'(ASCII_CR);
    localparam logic [DATA_W-1:0] LF_W = DATA_W'(ASCII_LF);

    uart_echo_state_t  state_q, state_d;
    logic              lf_pend_q, lf_pend_d;
    logic              start_q, start_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic              ovr_q, ovr_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    logic              push, pop, full, empty;
    logic [DATA_W-1:0] head;

    assign push = rx_valid & echo_en;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (rx_data),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        lf_pend_d = lf_pend_q;
        start_d   = 1'b0;
        data_d    = data_q;
        to_cnt_d  = to_cnt_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && !tx_busy) begin
                    pop       = 1'b1;
                    data_d    = head;
                    start_d   = 1'b1;
                    lf_pend_d = crlf_en && CRLF_OK && (head == CR_W);
                    to_cnt_d  = '0;
                    state_d   = ST_WAIT_ACK;
                end
            end
            // A transmitter that never acknowledges must not wedge the echo.
            ST_WAIT_ACK: begin
                if (tx_busy || to_cnt_q == TO_W'(ACK_TO - 1)) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = lf_pend_q ? ST_SEND_LF : ST_IDLE;
                end
            end
            ST_SEND_LF: begin
                if (!tx_busy) begin
                    data_d    = LF_W;
                    start_d   = 1'b1;
                    lf_pend_d = 1'b0;
                    to_cnt_d  = '0;
                    state_d   = ST_WAIT_ACK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        led_d = led_q;
        ovr_d = ovr_q;
        if (rx_valid) led_d = rx_data;
        if (clr_overrun) ovr_d = 1'b0;
        if (push && full && !pop) ovr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lf_pend_q <= 1'b0;
            start_q   <= 1'b0;
            data_q    <= '0;
            led_q     <= '0;
            ovr_q     <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            lf_pend_q <= lf_pend_d;
            start_q   <= start_d;
            data_q    <= data_d;
            led_q     <= led_d;
            ovr_q     <= ovr_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign tx_start   = start_q;
    assign tx_data    = data_q;
    assign led_output = led_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_echo_buf.sv
// Scenario bench for uart_echo_buf with a uart_tx busy model and a
// scoreboard of expected transmitted words.
module tb_uart_echo_buf;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ACK_TO = 4;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BUSY_LEN = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [DATA_W-1:0] rx_data = '0;
    logic              tx_busy = 1'b0;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              echo_en = 1'b0;
    logic              crlf_en = 1'b0;
    logic              clr_overrun = 1'b0;
    logic [DATA_W-1:0] led_output;
    logic [ADDR_W:0]   fifo_count;
    logic              overrun;

    int vec = 0;
    int errs = 0;
    int bm = 0;      // 0 auto busy model, 1 forced high, 2 tied low
    int bcnt = 0;
    logic [DATA_W-1:0] exp_q [$];

    uart_echo_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ACK_TO (ACK_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .echo_en     (echo_en),
        .crlf_en     (crlf_en),
        .clr_overrun (clr_overrun),
        .led_output  (led_output),
        .fifo_count  (fifo_count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bm == 1) begin
            tx_busy <= 1'b1;
            bcnt <= 0;
        end else if (bm == 2) begin
            tx_busy <= 1'b0;
            bcnt <= 0;
        end else if (tx_start) begin
            tx_busy <= 1'b1;
            bcnt <= BUSY_LEN;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else begin
            tx_busy <= 1'b0;
            bcnt <= 0;
        end
    end

    always @(negedge clk) begin
        logic [DATA_W-1:0] e;
        if (tx_start) begin
            vec++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_tx_start: tx_data=%h, none expected", tx_data);
            end else begin
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    errs++;
                    $display("FAIL tx_word: got %h want %h", tx_data, e);
                end
            end
            vec++;
            if (tx_busy !== 1'b0) begin
                errs++;
                $display("FAIL start_while_busy: tx_busy=%b want 0", tx_busy);
            end
        end
    end

    task automatic send(input logic [DATA_W-1:0] d);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data = d;
    endtask

    task automatic idle_rx();
        @(posedge clk); #1;
        rx_valid = 1'b0;
        clr_overrun = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && fifo_count == 0 && !tx_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (15) @(negedge clk);
        vec++;
        if (exp_q.size() != 0 || fifo_count !== '0) begin
            errs++;
            $display("FAIL drain_%s: left=%0d count=%0d want 0/0",
                     tag, exp_q.size(), fifo_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec++;
        if ({tx_start, tx_data, led_output, fifo_count, overrun} !== '0) begin
            errs++;
            $display("FAIL reset_state: start=%b data=%h led=%h cnt=%0d ovr=%b want all 0",
                     tx_start, tx_data, led_output, fifo_count, overrun);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        echo_en = 1'b1;
        bm = 0;
        send(8'h41);
        exp_q.push_back(8'h41);
        idle_rx();
        vec++;
        if (fifo_count !== 1 || led_output !== 8'h41) begin
            errs++;
            $display("FAIL single_queue: cnt=%0d led=%h want 1/41", fifo_count, led_output);
        end
        @(posedge clk); #1;
        vec++;
        if (tx_start !== 1'b1 || tx_data !== 8'h41) begin
            errs++;
            $display("FAIL single_latency: start=%b data=%h want 1/41", tx_start, tx_data);
        end
        drain("single");
    endtask

    task automatic test_burst();
        bm = 1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 18; i++) begin
            send(8'(i));
            if (i < DEPTH) exp_q.push_back(8'(i));
        end
        idle_rx();
        vec++;
        if (fifo_count !== DEPTH || overrun !== 1'b1 || led_output !== 8'h11) begin
            errs++;
            $display("FAIL burst_full: cnt=%0d ovr=%b led=%h want 16/1/11",
                     fifo_count, overrun, led_output);
        end
        bm = 0;
        drain("burst");
        @(posedge clk); #1;
        clr_overrun = 1'b1;
        idle_rx();
        vec++;
        if (overrun !== 1'b0) begin
            errs++;
            $display("FAIL burst_clr: ovr=%b want 0", overrun);
        end
    endtask

    task automatic test_crlf();
        crlf_en = 1'b1;
        send(8'h0D);
        send(8'h42);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h42);
        idle_rx();
        drain("crlf_on");
        crlf_en = 1'b0;
        send(8'h0D);
        send(8'h42);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h42);
        idle_rx();
        drain("crlf_off");
    endtask

    task automatic test_ack_timeout();
        int n;
        int gap;
        bm = 2;
        repeat (2) @(posedge clk);
        send(8'h55);
        send(8'h56);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h56);
        idle_rx();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 50);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!tx_start && gap < 50);
        vec++;
        if (gap != ACK_TO + 2) begin
            errs++;
            $display("FAIL ack_timeout_gap: got %0d cycles want %0d", gap, ACK_TO + 2);
        end
        drain("timeout");
        bm = 0;
    endtask

    task automatic test_full_pushpop();
        bm = 1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            send(8'h20 + 8'(i));
            exp_q.push_back(8'h20 + 8'(i));
        end
        send(8'h30);
        clr_overrun = 1'b1;
        idle_rx();
        vec++;
        if (overrun !== 1'b1 || fifo_count !== DEPTH || led_output !== 8'h30) begin
            errs++;
            $display("FAIL set_beats_clear: ovr=%b cnt=%0d led=%h want 1/16/30",
                     overrun, fifo_count, led_output);
        end
        clr_overrun = 1'b1;
        idle_rx();
        vec++;
        if (overrun !== 1'b0) begin
            errs++;
            $display("FAIL clr_alone: ovr=%b want 0", overrun);
        end
        bm = 0;
        send(8'h31);
        exp_q.push_back(8'h31);
        idle_rx();
        vec++;
        if (fifo_count !== DEPTH || overrun !== 1'b0) begin
            errs++;
            $display("FAIL full_pushpop: cnt=%0d ovr=%b want 16/0", fifo_count, overrun);
        end
        drain("full");
    endtask

    task automatic test_reset_mid();
        int starts;
        crlf_en = 1'b1;
        bm = 0;
        send(8'h0D);
        exp_q.push_back(8'h0D);
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
        idle_rx();
        vec++;
        if (fifo_count !== 5 || tx_busy !== 1'b1) begin
            errs++;
            $display("FAIL mid_setup: cnt=%0d busy=%b want 5/1", fifo_count, tx_busy);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vec++;
        if ({tx_start, tx_data, led_output, fifo_count, overrun} !== '0) begin
            errs++;
            $display("FAIL mid_reset: start=%b data=%h led=%h cnt=%0d ovr=%b want all 0",
                     tx_start, tx_data, led_output, fifo_count, overrun);
        end
        starts = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_start) starts++;
        end
        vec++;
        if (starts != 0 || exp_q.size() != 0) begin
            errs++;
            $display("FAIL mid_after: starts=%0d left=%0d want 0/0", starts, exp_q.size());
        end
        crlf_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_crlf();
        test_ack_timeout();
        test_full_pushpop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
